hv_timing_gen: RTL

- Parametrised raster timing generator for arcade cores, the successor to the fixed 336x240 generator.
- Produces pixel and line counters, blanking, active-low syncs, a frame-start strobe and blanked RGB.
- Runs on the core master clock, qualified by a pixel clock enable.
- Signed H/V sync offsets are latched once per frame, so line and frame length stay constant and the picture never tears when the user moves it.

---
 rtl/hv_timing_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hv_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, blanking, active-low syncs,
// frame-start strobe and blanked RGB, with per-frame latched signed sync offsets.
module hv_timing_gen #(
    parameter int H_ACTIVE     = 336,
    parameter int H_TOTAL      = 456,
    parameter int H_SYNC_START = 360,
    parameter int H_SYNC_WIDTH = 24,
    parameter int V_ACTIVE     = 240,
    parameter int V_TOTAL      = 262,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_WIDTH = 3,
    parameter int HW           = 9,
    parameter int VW           = 9,
    parameter int OFFS_W       = 5,
    parameter int H_OFFS_STEP  = 2,
    parameter int V_OFFS_STEP  = 1,
    parameter int LEAD         = 1,
    parameter int RGB_W        = 8
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              PCE,
    input  logic [OFFS_W-1:0] HOFFS,
    input  logic [OFFS_W-1:0] VOFFS,
    input  logic [RGB_W-1:0]  iRGB,
    output logic [HW-1:0]     HPOS,
    output logic [VW-1:0]     VPOS,
    output logic [RGB_W-1:0]  oRGB,
    output logic              HBLK,
    output logic              VBLK,
    output logic              HSYN,
    output logic              VSYN,
    output logic              FSTART
);

    localparam logic signed [HW+1:0] H_SS   = (HW+2)'(H_SYNC_START);
    localparam logic signed [HW+1:0] H_STEP = (HW+2)'(H_OFFS_STEP);
    localparam logic signed [HW+1:0] H_SWID = (HW+2)'(H_SYNC_WIDTH);
    localparam logic signed [HW+1:0] H_MIN  = (HW+2)'(H_ACTIVE);
    localparam logic signed [HW+1:0] H_MAX  = (HW+2)'(H_TOTAL - H_SYNC_WIDTH);
    localparam logic signed [VW+1:0] V_SS   = (VW+2)'(V_SYNC_START);
    localparam logic signed [VW+1:0] V_STEP = (VW+2)'(V_OFFS_STEP);
    localparam logic signed [VW+1:0] V_SWID = (VW+2)'(V_SYNC_WIDTH);
    localparam logic signed [VW+1:0] V_MIN  = (VW+2)'(V_ACTIVE);
    localparam logic signed [VW+1:0] V_MAX  = (VW+2)'(V_TOTAL - V_SYNC_WIDTH);

    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [OFFS_W-1:0] hoffs_l_q, hoffs_l_d;
    logic [OFFS_W-1:0] voffs_l_q, voffs_l_d;
    logic              hblk_q, hblk_d;
    logic              vblk_q, vblk_d;
    logic              hsyn_q, hsyn_d;
    logic              vsyn_q, vsyn_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              fstart_q, fstart_d;

    logic              h_last, v_last, frame_wrap;
    logic signed [HW+1:0] hoffs_sx, hs_raw, hs_b, hcnt_sx;
    logic signed [VW+1:0] voffs_sx, vs_raw, vs_b, vcnt_sx;
    logic [HW:0]       hpos_sum;

    assign h_last     = (hcnt_q == HW'(H_TOTAL - 1));
    assign v_last     = (vcnt_q == VW'(V_TOTAL - 1));
    assign frame_wrap = h_last && v_last;

    assign hoffs_sx = {{(HW+2-OFFS_W){hoffs_l_q[OFFS_W-1]}}, hoffs_l_q};
    assign voffs_sx = {{(VW+2-OFFS_W){voffs_l_q[OFFS_W-1]}}, voffs_l_q};
    assign hcnt_sx  = {2'b00, hcnt_q};
    assign vcnt_sx  = {2'b00, vcnt_q};
    assign hs_raw   = H_SS + hoffs_sx * H_STEP;
    assign vs_raw   = V_SS + voffs_sx * V_STEP;

    // Sync start is clamped so the pulse never enters the active area or spills past the line/frame end.
    always_comb begin
        hs_b = hs_raw;
        if (hs_raw < H_MIN) hs_b = H_MIN;
        else if (hs_raw > H_MAX) hs_b = H_MAX;
        vs_b = vs_raw;
        if (vs_raw < V_MIN) vs_b = V_MIN;
        else if (vs_raw > V_MAX) vs_b = V_MAX;
    end

    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        hoffs_l_d = hoffs_l_q;
        voffs_l_d = voffs_l_q;
        hblk_d    = hblk_q;
        vblk_d    = vblk_q;
        hsyn_d    = hsyn_q;
        vsyn_d    = vsyn_q;
        rgb_d     = rgb_q;
        fstart_d  = 1'b0;
        if (PCE) begin
            hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
            if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            if (frame_wrap) begin
                hoffs_l_d = HOFFS;
                voffs_l_d = VOFFS;
                fstart_d  = 1'b1;
            end
            hblk_d = (hcnt_q >= HW'(H_ACTIVE));
            vblk_d = (vcnt_q >= VW'(V_ACTIVE));
            hsyn_d = !((hcnt_sx >= hs_b) && (hcnt_sx < hs_b + H_SWID));
            vsyn_d = !((vcnt_sx >= vs_b) && (vcnt_sx < vs_b + V_SWID));
            rgb_d  = ((hcnt_q >= HW'(H_ACTIVE)) || (vcnt_q >= VW'(V_ACTIVE))) ? '0 : iRGB;
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hoffs_l_q <= HOFFS;
            voffs_l_q <= VOFFS;
            hblk_q    <= 1'b1;
            vblk_q    <= 1'b1;
            hsyn_q    <= 1'b1;
            vsyn_q    <= 1'b1;
            rgb_q     <= '0;
            fstart_q  <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hoffs_l_q <= hoffs_l_d;
            voffs_l_q <= voffs_l_d;
            hblk_q    <= hblk_d;
            vblk_q    <= vblk_d;
            hsyn_q    <= hsyn_d;
            vsyn_q    <= vsyn_d;
            rgb_q     <= rgb_d;
            fstart_q  <= fstart_d;
        end
    end

    // Fetch column leads the counter and wraps modulo the line length.
    assign hpos_sum = {1'b0, hcnt_q} + (HW+1)'(LEAD);
    assign HPOS     = (hpos_sum >= (HW+1)'(H_TOTAL)) ? HW'(hpos_sum - (HW+1)'(H_TOTAL))
                                                     : hpos_sum[HW-1:0];
    assign VPOS     = vcnt_q;
    assign oRGB     = rgb_q;
    assign HBLK     = hblk_q;
    assign VBLK     = vblk_q;
    assign HSYN     = hsyn_q;
    assign VSYN     = vsyn_q;
    assign FSTART   = fstart_q;

endmodule
